// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants and types for the MCU reassembly stage.
//   MODE_444 / MODE_420      chroma mode encodings (mode_420 port value)
//   NBLK_444 / NBLK_420      blocks per MCU
//   MCU_DIM_444/MCU_DIM_420  MCU edge length in pixels
//   COMP_Y/COMP_CB/COMP_CR   component ids
//   sched_state_t            scheduler FSM states
package jpeg_pkg;

   localparam logic MODE_444 = 1'b0;
   localparam logic MODE_420 = 1'b1;

   localparam int unsigned NBLK_444    = 3;
   localparam int unsigned NBLK_420    = 6;
   localparam int unsigned MCU_DIM_444 = 8;
   localparam int unsigned MCU_DIM_420 = 16;

   localparam logic [1:0] COMP_Y  = 2'd0;
   localparam logic [1:0] COMP_CB = 2'd1;
   localparam logic [1:0] COMP_CR = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_FLUSH,
      ST_DONE
   } sched_state_t;

   // Component carried by block idx within an MCU.
   function automatic logic [1:0] comp_of_blk(input logic mode, input logic [2:0] idx);
      if (mode == MODE_420) begin
         if (idx < 3'd4)       return COMP_Y;
         else if (idx == 3'd4) return COMP_CB;
         else                  return COMP_CR;
      end else begin
         if (idx == 3'd0)      return COMP_Y;
         else if (idx == 3'd1) return COMP_CB;
         else                  return COMP_CR;
      end
   endfunction

   // Index of the final block of an MCU.
   function automatic logic [2:0] last_blk_idx(input logic mode);
      return (mode == MODE_420) ? 3'(NBLK_420 - 1) : 3'(NBLK_444 - 1);
   endfunction

endpackage

// File: rtl/mcu_pixel_tracker.sv
// mcu_pixel_tracker: raster row/col counters within the current MCU and
// image-coordinate tagging of each flushed pixel.
//   clk, rst        clock, async active-high reset
//   clr             synchronous counter clear
//   pix_en          qualified pixel strobe (only while flushing)
//   mode_420        latched mode: 16x16 MCU when 1, 8x8 when 0
//   mcu_x, mcu_y    current MCU position
//   width, height   latched image dimensions
//   mcu_last_pix    pix_en on the final pixel of the MCU
//   pix_x, pix_y    image coordinates of the current pixel
//   pix_keep        pix_en and pixel lies inside the image
module mcu_pixel_tracker
   import jpeg_pkg::*;
#(
   parameter int unsigned DIM_W  = 16,
   parameter int unsigned MCU_CW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              pix_en,
   input  logic              mode_420,
   input  logic [MCU_CW-1:0] mcu_x,
   input  logic [MCU_CW-1:0] mcu_y,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   output logic              mcu_last_pix,
   output logic [DIM_W-1:0]  pix_x,
   output logic [DIM_W-1:0]  pix_y,
   output logic              pix_keep
);

   // One extra bit so the edge compare never wraps.
   localparam int unsigned CW = DIM_W + 1;

   logic [3:0]    row;
   logic [3:0]    col;
   logic [3:0]    dim_m1;
   logic [2:0]    shamt;
   logic [CW-1:0] x_ext;
   logic [CW-1:0] y_ext;

   always_comb begin
      dim_m1       = mode_420 ? 4'(MCU_DIM_420 - 1) : 4'(MCU_DIM_444 - 1);
      shamt        = mode_420 ? 3'd4 : 3'd3;
      x_ext        = (CW'(mcu_x) << shamt) + CW'(col);
      y_ext        = (CW'(mcu_y) << shamt) + CW'(row);
      pix_x        = x_ext[DIM_W-1:0];
      pix_y        = y_ext[DIM_W-1:0];
      pix_keep     = pix_en && (x_ext < CW'(width)) && (y_ext < CW'(height));
      mcu_last_pix = pix_en && (row == dim_m1) && (col == dim_m1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (pix_en) begin
         if (col == dim_m1) begin
            col <= '0;
            row <= (row == dim_m1) ? '0 : row + 4'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mcu_scheduler.sv
// mcu_scheduler: frame-level sequencer for MCU reassembly. Issues one block
// request at a time (component id per block), gates requests on buffer
// readiness, walks MCUs over the image and pulses frame_done.
//   clk, rst                  clock, async active-high reset
//   start, abort              frame start pulse / synchronous abort
//   img_width, img_height     image size, sampled on start
//   mode_420                  1 = 4:2:0, 0 = 4:4:4, sampled on start
//   blk_req_valid/ready       block request handshake
//   blk_comp_id, blk_idx      component and in-MCU index of request
//   blk_done                  block delivered to MCU buffer
//   sink_ready                MCU buffer ready
//   pix_valid_in              MCU buffer pixel strobe
//   pix_x, pix_y, pix_keep    pixel coordinate tag and in-image flag
//   busy, frame_done, cfg_err status
module mcu_scheduler
   import jpeg_pkg::*;
#(
   parameter int unsigned DIM_W  = 16,
   parameter int unsigned MCU_CW = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIM_W-1:0] img_width,
   input  logic [DIM_W-1:0] img_height,
   input  logic             mode_420,
   output logic             blk_req_valid,
   input  logic             blk_req_ready,
   output logic [1:0]       blk_comp_id,
   output logic [2:0]       blk_idx,
   input  logic             blk_done,
   input  logic             sink_ready,
   input  logic             pix_valid_in,
   output logic [DIM_W-1:0] pix_x,
   output logic [DIM_W-1:0] pix_y,
   output logic             pix_keep,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err
);

   localparam int unsigned CW = DIM_W + 1;

   sched_state_t      state, state_nx;
   logic [DIM_W-1:0]  width_r, height_r;
   logic              mode_r;
   logic [MCU_CW-1:0] mcus_x_r, mcus_y_r;
   logic [MCU_CW-1:0] mcu_x, mcu_y;
   logic [2:0]        idx;

   logic              start_ok;
   logic              last_blk;
   logic              last_mcu;
   logic              last_col;
   logic              flush_en;
   logic              trk_clr;
   logic              mcu_done;
   logic [CW-1:0]     w_round, h_round;
   logic [MCU_CW-1:0] mcus_x_nx, mcus_y_nx;

   always_comb begin
      start_ok  = start && (img_width != '0) && (img_height != '0);
      // ceil(dim / MCU) as (dim + MCU-1) >> log2(MCU), widened so it cannot overflow
      w_round   = CW'(img_width)  + (mode_420 ? CW'(MCU_DIM_420 - 1) : CW'(MCU_DIM_444 - 1));
      h_round   = CW'(img_height) + (mode_420 ? CW'(MCU_DIM_420 - 1) : CW'(MCU_DIM_444 - 1));
      mcus_x_nx = mode_420 ? MCU_CW'(w_round >> 4) : MCU_CW'(w_round >> 3);
      mcus_y_nx = mode_420 ? MCU_CW'(h_round >> 4) : MCU_CW'(h_round >> 3);
      last_blk  = (idx == last_blk_idx(mode_r));
      last_col  = (mcu_x == mcus_x_r - MCU_CW'(1));
      last_mcu  = last_col && (mcu_y == mcus_y_r - MCU_CW'(1));
      flush_en  = (state == ST_FLUSH) && pix_valid_in;
      trk_clr   = abort || (state == ST_IDLE);
   end

   mcu_pixel_tracker #(
      .DIM_W  (DIM_W),
      .MCU_CW (MCU_CW)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .clr          (trk_clr),
      .pix_en       (flush_en),
      .mode_420     (mode_r),
      .mcu_x        (mcu_x),
      .mcu_y        (mcu_y),
      .width        (width_r),
      .height       (height_r),
      .mcu_last_pix (mcu_done),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_keep     (pix_keep)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next state; abort overrides every other event
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_REQ;
            ST_REQ:   if (blk_req_valid && blk_req_ready) state_nx = ST_WAIT;
            ST_WAIT:  if (blk_done) state_nx = last_blk ? ST_FLUSH : ST_REQ;
            ST_FLUSH: if (mcu_done) state_nx = last_mcu ? ST_DONE : ST_REQ;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      blk_req_valid = (state == ST_REQ) && sink_ready;
      blk_comp_id   = comp_of_blk(mode_r, idx);
      blk_idx       = idx;
      busy          = (state != ST_IDLE);
      frame_done    = (state == ST_DONE);
   end

   // Config latch, block index and MCU position
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_r  <= '0;
         height_r <= '0;
         mode_r   <= MODE_444;
         mcus_x_r <= '0;
         mcus_y_r <= '0;
         mcu_x    <= '0;
         mcu_y    <= '0;
         idx      <= '0;
         cfg_err  <= 1'b0;
      end else if (abort) begin
         mcu_x <= '0;
         mcu_y <= '0;
         idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cfg_err <= !start_ok;
                  if (start_ok) begin
                     width_r  <= img_width;
                     height_r <= img_height;
                     mode_r   <= mode_420;
                     mcus_x_r <= mcus_x_nx;
                     mcus_y_r <= mcus_y_nx;
                     mcu_x    <= '0;
                     mcu_y    <= '0;
                     idx      <= '0;
                  end
               end
            end
            ST_WAIT: begin
               if (blk_done) idx <= last_blk ? '0 : idx + 3'd1;
            end
            ST_FLUSH: begin
               if (mcu_done && !last_mcu) begin
                  if (last_col) begin
                     mcu_x <= '0;
                     mcu_y <= mcu_y + MCU_CW'(1);
                  end else begin
                     mcu_x <= mcu_x + MCU_CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_scheduler.sv
module tb_mcu_scheduler;
   import jpeg_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] img_width = '0;
   logic [15:0] img_height = '0;
   logic        mode_420 = 1'b0;
   logic        blk_req_valid;
   logic        blk_req_ready = 1'b1;
   logic [1:0]  blk_comp_id;
   logic [2:0]  blk_idx;
   logic        blk_done = 1'b0;
   logic        sink_ready = 1'b1;
   logic        pix_valid_in = 1'b0;
   logic [15:0] pix_x, pix_y;
   logic        pix_keep, busy, frame_done, cfg_err;

   always #5 clk = ~clk;

   mcu_scheduler #(
      .DIM_W  (16),
      .MCU_CW (12)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .img_width     (img_width),
      .img_height    (img_height),
      .mode_420      (mode_420),
      .blk_req_valid (blk_req_valid),
      .blk_req_ready (blk_req_ready),
      .blk_comp_id   (blk_comp_id),
      .blk_idx       (blk_idx),
      .blk_done      (blk_done),
      .sink_ready    (sink_ready),
      .pix_valid_in  (pix_valid_in),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_keep      (pix_keep),
      .busy          (busy),
      .frame_done    (frame_done),
      .cfg_err       (cfg_err)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor: samples on the falling edge, inputs change at posedge+1.
   logic [1:0]  acc_comp[$];
   logic [2:0]  acc_idx[$];
   int unsigned pix_cnt = 0, keep_cnt = 0, fd_cnt = 0, fd_late = 0, hold_viol = 0;
   int unsigned last_kx = 0, last_ky = 0;
   logic        acc_evt = 1'b0, prev_stall = 1'b0, prev_pix = 1'b0;
   logic [1:0]  prev_comp = '0;
   logic [2:0]  prev_idx = '0;

   always @(negedge clk) begin
      if (rst) begin
         acc_evt    = 1'b0;
         prev_stall = 1'b0;
         prev_pix   = 1'b0;
      end else begin
         if (prev_stall && !(blk_req_valid && blk_comp_id == prev_comp && blk_idx == prev_idx))
            hold_viol++;
         acc_evt = blk_req_valid && blk_req_ready;
         if (acc_evt) begin
            acc_comp.push_back(blk_comp_id);
            acc_idx.push_back(blk_idx);
         end
         if (pix_valid_in) pix_cnt++;
         if (pix_keep) begin
            keep_cnt++;
            last_kx = pix_x;
            last_ky = pix_y;
         end
         if (frame_done) begin
            fd_cnt++;
            if (!prev_pix) fd_late++;
         end
         prev_stall = blk_req_valid && !blk_req_ready;
         prev_comp  = blk_comp_id;
         prev_idx   = blk_idx;
         prev_pix   = pix_valid_in;
      end
   end

   // Pipe + MCU buffer model: blk_done 3 cycles after each accepted request,
   // then a full MCU of pixels after the last block of the MCU.
   logic        resp_clear = 1'b0;
   int unsigned r_wait = 0, r_blks = 0, r_pix = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         blk_done     = 1'b0;
         pix_valid_in = 1'b0;
         if (rst || resp_clear) begin
            r_wait = 0;
            r_blks = 0;
            r_pix  = 0;
         end else if (r_pix != 0) begin
            pix_valid_in = 1'b1;
            r_pix--;
         end else if (r_wait != 0) begin
            r_wait--;
            if (r_wait == 0) begin
               blk_done = 1'b1;
               r_blks++;
               if (r_blks == (mode_420 ? 6 : 3)) begin
                  r_blks = 0;
                  r_pix  = mode_420 ? 256 : 64;
               end
            end
         end else if (acc_evt) begin
            r_wait = 2;
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic kick(input logic [15:0] w, input logic [15:0] h, input logic m);
      img_width  = w;
      img_height = h;
      mode_420   = m;
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int unsigned f0, input int unsigned budget);
      for (int unsigned i = 0; i < budget && fd_cnt == f0; i++) tick(1);
      tick(3);
      check(tag, fd_cnt - f0, 1);
   endtask

   task automatic check_seq(input string tag, input int unsigned base, input logic m);
      logic [1:0] exp420[6];
      int unsigned n;
      exp420 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
      n = m ? 6 : 3;
      for (int unsigned i = 0; base + i < acc_comp.size(); i++) begin
         check($sformatf("%s_comp%0d", tag, i), acc_comp[base+i], m ? exp420[i%6] : i % 3);
         check($sformatf("%s_idx%0d", tag, i), acc_idx[base+i], i % n);
      end
   endtask

   int unsigned base, k0, p0, f0, vmax;

   initial begin
      // Reset state
      tick(3);
      check("rst_busy", busy, 0);
      check("rst_valid", blk_req_valid, 0);
      check("rst_fd", frame_done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_pix", {pix_keep, pix_x, pix_y}, 0);
      rst = 1'b0;
      tick(2);

      // 4:4:4 16x8: 2 MCUs, 6 requests, 128 kept pixels
      base = acc_comp.size(); k0 = keep_cnt; p0 = pix_cnt; f0 = fd_cnt;
      kick(16'd16, 16'd8, 1'b0);
      check("t1_busy", busy, 1);
      wait_done("t1_done", f0, 3000);
      check("t1_nreq", acc_comp.size() - base, 6);
      check_seq("t1", base, 1'b0);
      check("t1_keep", keep_cnt - k0, 128);
      check("t1_pix", pix_cnt - p0, 128);
      check("t1_fd_lat", fd_late, 0);
      check("t1_idle", busy, 0);

      // 4:2:0 20x20: 2x2 MCUs, 24 requests, 1024 pixels, 400 kept
      base = acc_comp.size(); k0 = keep_cnt; p0 = pix_cnt; f0 = fd_cnt;
      kick(16'd20, 16'd20, 1'b1);
      wait_done("t2_done", f0, 5000);
      check("t2_nreq", acc_comp.size() - base, 24);
      check_seq("t2", base, 1'b1);
      check("t2_pix", pix_cnt - p0, 1024);
      check("t2_keep", keep_cnt - k0, 400);
      check("t2_last_x", last_kx, 19);
      check("t2_last_y", last_ky, 19);
      check("t2_fd_lat", fd_late, 0);

      // Pipe backpressure: ready low for 5 cycles with the request pending
      base = acc_comp.size(); f0 = fd_cnt;
      blk_req_ready = 1'b0;
      kick(16'd16, 16'd8, 1'b0);
      for (int unsigned i = 0; i < 5; i++) begin
         check($sformatf("t3_hold_valid%0d", i), blk_req_valid, 1);
         check($sformatf("t3_hold_idx%0d", i), blk_idx, 0);
         tick(1);
      end
      blk_req_ready = 1'b1;
      wait_done("t3_done", f0, 3000);
      check("t3_nreq", acc_comp.size() - base, 6);
      check_seq("t3", base, 1'b0);
      check("t3_hold_viol", hold_viol, 0);

      // Buffer not ready: no request until sink_ready rises
      base = acc_comp.size(); f0 = fd_cnt; vmax = 0;
      sink_ready = 1'b0;
      kick(16'd16, 16'd8, 1'b0);
      for (int unsigned i = 0; i < 10; i++) begin
         if (blk_req_valid) vmax = 1;
         tick(1);
      end
      check("t4_no_valid", vmax, 0);
      sink_ready = 1'b1;
      #1;
      check("t4_valid_same_cycle", blk_req_valid, 1);
      check("t4_first_idx", blk_idx, 0);
      wait_done("t4_done", f0, 3000);
      check("t4_nreq", acc_comp.size() - base, 6);

      // Abort while waiting on the 3rd block of MCU 1
      base = acc_comp.size(); f0 = fd_cnt;
      kick(16'd16, 16'd8, 1'b0);
      for (int unsigned i = 0; i < 500 && acc_comp.size() < base + 6; i++) tick(1);
      check("t5_reached", acc_comp.size() - base, 6);
      check("t5_idx", blk_idx, 2);
      abort      = 1'b1;
      resp_clear = 1'b1;
      tick(1);
      abort = 1'b0;
      check("t5_busy", busy, 0);
      tick(20);
      resp_clear = 1'b0;
      check("t5_no_fd", fd_cnt - f0, 0);
      check("t5_valid", blk_req_valid, 0);
      base = acc_comp.size(); k0 = keep_cnt; f0 = fd_cnt;
      kick(16'd16, 16'd8, 1'b0);
      wait_done("t5_restart_done", f0, 3000);
      check("t5_restart_nreq", acc_comp.size() - base, 6);
      check_seq("t5r", base, 1'b0);
      check("t5_restart_keep", keep_cnt - k0, 128);

      // Zero width: cfg_err set, stays idle; cleared by the next good start
      kick(16'd0, 16'd8, 1'b0);
      check("t6_cfg_err", cfg_err, 1);
      check("t6_busy", busy, 0);
      tick(3);
      check("t6_still_idle", {busy, blk_req_valid}, 0);
      check("t6_sticky", cfg_err, 1);
      p0 = pix_cnt; f0 = fd_cnt;
      kick(16'd16, 16'd16, 1'b1);
      check("t6_cfg_err_clr", cfg_err, 0);

      // Async reset mid-flush
      for (int unsigned i = 0; i < 500 && pix_cnt == p0; i++) tick(1);
      check("t7_in_flush", (pix_cnt > p0) ? 1 : 0, 1);
      rst = 1'b1;
      #1;
      check("t7_busy", busy, 0);
      check("t7_req", {blk_req_valid, blk_comp_id, blk_idx}, 0);
      check("t7_pix", {pix_keep, pix_x, pix_y}, 0);
      check("t7_flags", {frame_done, cfg_err}, 0);
      tick(5);
      check("t7_no_fd", fd_cnt - f0, 0);
      rst = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
